// File: rtl/rvc_asap_eot_ctrl_if.sv
// rvc_asap_eot_ctrl_if
//   Bundles the two handshaked paths of the end-of-test controller:
//   - D_MEM read port: MemRdEn/MemRdAddr request, MemRdData returned one cycle later.
//   - Snapshot stream: DumpValid/DumpAddr/DumpData/DumpLast offered, DumpReady accepts.
//   master : the controller (issues reads, produces the stream).
//   slave  : memory and stream consumer side.
interface rvc_asap_eot_ctrl_if;
  logic        MemRdEn;
  logic [31:0] MemRdAddr;
  logic [31:0] MemRdData;
  logic        DumpValid;
  logic        DumpReady;
  logic [31:0] DumpAddr;
  logic [31:0] DumpData;
  logic        DumpLast;

  modport master (
    output MemRdEn,
    output MemRdAddr,
    input  MemRdData,
    output DumpValid,
    output DumpAddr,
    output DumpData,
    output DumpLast,
    input  DumpReady
  );

  modport slave (
    input  MemRdEn,
    input  MemRdAddr,
    output MemRdData,
    input  DumpValid,
    input  DumpAddr,
    input  DumpData,
    input  DumpLast,
    output DumpReady
  );
endinterface

// File: rtl/rvc_asap_eot_ctrl.sv
// rvc_asap_eot_ctrl
//   End-of-test controller for the rvc_asap cores. Watches NUM_LANES retiring
//   instruction lanes for EOT_OPCODE and runs a cycle watchdog. On either event
//   the cycle count freezes and the data-memory window
//   [DUMP_BASE, DUMP_BASE + 4*DUMP_WORDS) is read through a 1-cycle-latency port
//   and streamed out as address/data words over valid/ready.
// Ports
//   Clock     : rising-edge clock.
//   Rst       : synchronous active-high reset; returns to RUN, flushes the dump path.
//   InstValid : per-lane valid.
//   Instr     : lane i at bits [32i+31:32i].
//   bus       : memory read port and snapshot stream (master side).
//   Done      : sticky, test finished and dump complete.
//   EotCause  : 00 none, 01 opcode, 10 watchdog.
//   EotLane   : lowest matching lane, 0 on watchdog.
//   CycleCnt  : saturating count of RUN cycles, frozen at trigger.
module rvc_asap_eot_ctrl #(
  parameter int unsigned NUM_LANES      = 1,
  parameter logic [31:0] EOT_OPCODE     = 32'h00100073,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [31:0] DUMP_BASE      = 32'h00001000,
  parameter int unsigned DUMP_WORDS     = 1024
) (
  input  logic                                                  Clock,
  input  logic                                                  Rst,
  input  logic [NUM_LANES-1:0]                                  InstValid,
  input  logic [32*NUM_LANES-1:0]                               Instr,
  rvc_asap_eot_ctrl_if.master                                   bus,
  output logic                                                  Done,
  output logic [1:0]                                            EotCause,
  output logic [((NUM_LANES > 1) ? $clog2(NUM_LANES) : 1)-1:0]  EotLane,
  output logic [31:0]                                           CycleCnt
);

  localparam int unsigned LW          = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [31:0] LastIdx     = 32'(DUMP_WORDS - 1);
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES) - 32'd1;
  localparam bit          WatchdogEn  = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] CauseNone    = 2'b00;
  localparam logic [1:0] CauseOpcode  = 2'b01;
  localparam logic [1:0] CauseTimeout = 2'b10;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StDump = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [31:0]   cycle_cnt_q, cycle_cnt_d;
  logic [1:0]    cause_q, cause_d;
  logic [LW-1:0] lane_q, lane_d;

  // Read issue side
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [31:0] rd_idx_q, rd_idx_d;
  logic        rd_all_q, rd_all_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_addr_q, inflight_addr_d;
  logic        inflight_last_q, inflight_last_d;

  // 2-entry output FIFO
  logic [1:0][31:0] fifo_addr_q, fifo_addr_d;
  logic [1:0][31:0] fifo_data_q, fifo_data_d;
  logic [1:0]       fifo_last_q, fifo_last_d;
  logic             fifo_wptr_q, fifo_wptr_d;
  logic             fifo_rptr_q, fifo_rptr_d;
  logic [1:0]       fifo_cnt_q, fifo_cnt_d;

  logic                 dump_valid;
  logic                 pop;
  logic                 push;
  logic                 rd_en;
  logic                 timeout;
  logic [NUM_LANES-1:0] lane_match;
  logic                 any_match;
  logic [LW-1:0]        match_lane;

  // Lane matching; the descending scan leaves the lowest matching lane.
  always_comb begin
    lane_match = '0;
    match_lane = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      lane_match[i] = InstValid[i] && (Instr[32*i +: 32] == EOT_OPCODE);
    end
    for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
      if (lane_match[i]) begin
        match_lane = LW'(i);
      end
    end
  end

  assign any_match = |lane_match;
  assign timeout   = WatchdogEn && (cycle_cnt_q == TimeoutLast);

  assign dump_valid = (fifo_cnt_q != 2'd0);
  assign pop        = dump_valid && bus.DumpReady;
  // The word read last cycle lands in the FIFO now.
  assign push       = inflight_q;

  // Reserve a FIFO slot for every outstanding read so backpressure never drops data.
  assign rd_en = (state_q == StDump) && !rd_all_q &&
                 (({1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);

  always_comb begin
    state_d         = state_q;
    cycle_cnt_d     = cycle_cnt_q;
    cause_d         = cause_q;
    lane_d          = lane_q;
    rd_addr_d       = rd_addr_q;
    rd_idx_d        = rd_idx_q;
    rd_all_d        = rd_all_q;
    inflight_d      = 1'b0;
    inflight_addr_d = inflight_addr_q;
    inflight_last_d = inflight_last_q;
    fifo_addr_d     = fifo_addr_q;
    fifo_data_d     = fifo_data_q;
    fifo_last_d     = fifo_last_q;
    fifo_wptr_d     = fifo_wptr_q;
    fifo_rptr_d     = fifo_rptr_q;
    fifo_cnt_d      = fifo_cnt_q;

    unique case (state_q)
      StRun: begin
        // Opcode is checked first so it wins over a simultaneous watchdog.
        if (any_match) begin
          cause_d = CauseOpcode;
          lane_d  = match_lane;
          state_d = StDump;
        end else if (timeout) begin
          cause_d = CauseTimeout;
          lane_d  = '0;
          state_d = StDump;
        end else if (cycle_cnt_q != 32'hFFFF_FFFF) begin
          cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
      end
      StDump: begin
        if (pop && fifo_last_q[fifo_rptr_q]) begin
          state_d = StDone;
        end
      end
      StDone: begin
      end
      default: begin
        state_d = StRun;
      end
    endcase

    if (rd_en) begin
      inflight_d      = 1'b1;
      inflight_addr_d = rd_addr_q;
      inflight_last_d = (rd_idx_q == LastIdx);
      rd_addr_d       = rd_addr_q + 32'd4;
      rd_idx_d        = rd_idx_q + 32'd1;
      if (rd_idx_q == LastIdx) begin
        rd_all_d = 1'b1;
      end
    end

    if (push) begin
      fifo_addr_d[fifo_wptr_q] = inflight_addr_q;
      fifo_data_d[fifo_wptr_q] = bus.MemRdData;
      fifo_last_d[fifo_wptr_q] = inflight_last_q;
      fifo_wptr_d              = ~fifo_wptr_q;
    end
    if (pop) begin
      fifo_rptr_d = ~fifo_rptr_q;
    end
    fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_q         <= StRun;
      cycle_cnt_q     <= '0;
      cause_q         <= CauseNone;
      lane_q          <= '0;
      rd_addr_q       <= DUMP_BASE;
      rd_idx_q        <= '0;
      rd_all_q        <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      inflight_last_q <= 1'b0;
      fifo_addr_q     <= '0;
      fifo_data_q     <= '0;
      fifo_last_q     <= '0;
      fifo_wptr_q     <= 1'b0;
      fifo_rptr_q     <= 1'b0;
      fifo_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      cycle_cnt_q     <= cycle_cnt_d;
      cause_q         <= cause_d;
      lane_q          <= lane_d;
      rd_addr_q       <= rd_addr_d;
      rd_idx_q        <= rd_idx_d;
      rd_all_q        <= rd_all_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      inflight_last_q <= inflight_last_d;
      fifo_addr_q     <= fifo_addr_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
      fifo_wptr_q     <= fifo_wptr_d;
      fifo_rptr_q     <= fifo_rptr_d;
      fifo_cnt_q      <= fifo_cnt_d;
    end
  end

  assign bus.MemRdEn   = rd_en;
  assign bus.MemRdAddr = rd_addr_q;
  // Head fields are masked to zero while the FIFO is empty.
  assign bus.DumpValid = dump_valid;
  assign bus.DumpAddr  = dump_valid ? fifo_addr_q[fifo_rptr_q] : 32'd0;
  assign bus.DumpData  = dump_valid ? fifo_data_q[fifo_rptr_q] : 32'd0;
  assign bus.DumpLast  = dump_valid && fifo_last_q[fifo_rptr_q];

  assign Done     = (state_q == StDone);
  assign EotCause = cause_q;
  assign EotLane  = lane_q;
  assign CycleCnt = cycle_cnt_q;

endmodule

// File: tb/tb_rvc_asap_eot_ctrl.sv
`timescale 1ns/1ps
module tb_rvc_asap_eot_ctrl;
  localparam logic [31:0] Ebreak = 32'h00100073;
  localparam logic [31:0] Nop    = 32'h00000013;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // DUT A: 4 lanes, watchdog 50, 4-word dump
  logic         Rst_a;
  logic [3:0]   InstValid_a;
  logic [127:0] Instr_a;
  logic         Done_a;
  logic [1:0]   EotCause_a;
  logic [1:0]   EotLane_a;
  logic [31:0]  CycleCnt_a;
  rvc_asap_eot_ctrl_if bus_a ();

  rvc_asap_eot_ctrl #(
    .NUM_LANES      (4),
    .TIMEOUT_CYCLES (50),
    .DUMP_WORDS     (4)
  ) dut_a (
    .Clock     (Clock),
    .Rst       (Rst_a),
    .InstValid (InstValid_a),
    .Instr     (Instr_a),
    .bus       (bus_a),
    .Done      (Done_a),
    .EotCause  (EotCause_a),
    .EotLane   (EotLane_a),
    .CycleCnt  (CycleCnt_a)
  );

  // DUT B: 1 lane, default watchdog, 8-word dump
  logic        Rst_b;
  logic [0:0]  InstValid_b;
  logic [31:0] Instr_b;
  logic        Done_b;
  logic [1:0]  EotCause_b;
  logic [0:0]  EotLane_b;
  logic [31:0] CycleCnt_b;
  rvc_asap_eot_ctrl_if bus_b ();

  rvc_asap_eot_ctrl #(
    .NUM_LANES  (1),
    .DUMP_WORDS (8)
  ) dut_b (
    .Clock     (Clock),
    .Rst       (Rst_b),
    .InstValid (InstValid_b),
    .Instr     (Instr_b),
    .bus       (bus_b),
    .Done      (Done_b),
    .EotCause  (EotCause_b),
    .EotLane   (EotLane_b),
    .CycleCnt  (CycleCnt_b)
  );

  // Memory models: word k of the window holds 'hA0 + k
  always @(posedge Clock) begin
    if (bus_a.MemRdEn) bus_a.MemRdData <= 32'hA0 + ((bus_a.MemRdAddr - 32'h1000) >> 2);
    if (bus_b.MemRdEn) bus_b.MemRdData <= 32'hA0 + ((bus_b.MemRdAddr - 32'h1000) >> 2);
  end

  // Outstanding words of DUT B (issued reads not yet accepted downstream)
  int unsigned iss_b = 0;
  int unsigned acc_b = 0;
  always @(posedge Clock) begin
    if (Rst_b) begin
      iss_b <= 0;
      acc_b <= 0;
    end else begin
      iss_b <= iss_b + 32'(bus_b.MemRdEn);
      acc_b <= acc_b + 32'(bus_b.DumpValid && bus_b.DumpReady);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_b(input string tag);
    check_eq({tag, "_done"},  32'(Done_b), 0);
    check_eq({tag, "_cause"}, 32'(EotCause_b), 0);
    check_eq({tag, "_lane"},  32'(EotLane_b), 0);
    check_eq({tag, "_cnt"},   CycleCnt_b, 0);
    check_eq({tag, "_rden"},  32'(bus_b.MemRdEn), 0);
    check_eq({tag, "_rdadr"}, bus_b.MemRdAddr, 32'h1000);
    check_eq({tag, "_valid"}, 32'(bus_b.DumpValid), 0);
    check_eq({tag, "_daddr"}, bus_b.DumpAddr, 0);
    check_eq({tag, "_ddata"}, bus_b.DumpData, 0);
    check_eq({tag, "_dlast"}, 32'(bus_b.DumpLast), 0);
  endtask

  // Reset B, trigger it in the first run cycle and check the trigger took.
  task automatic start_b(input string tag);
    Rst_b = 1'b1;
    InstValid_b = 1'b0;
    repeat (2) @(negedge Clock);
    Rst_b = 1'b0;
    InstValid_b = 1'b1;
    Instr_b = Ebreak;
    @(negedge Clock);
    InstValid_b = 1'b0;
    check_eq({tag, "_cause"}, 32'(EotCause_b), 1);
    check_eq({tag, "_cnt"}, CycleCnt_b, 0);
  endtask

  // Drain DUT B, optionally with the 1,0,0,1,0,1 ready pattern.
  task automatic collect_b(input bit bp, input string tag);
    logic [5:0]  rdy_pat = 6'b101001;
    int unsigned nw = 0;
    int unsigned stall_bad = 0;
    int unsigned max_out = 0;
    bit          prev_stall = 1'b0;
    bit          done_seen = 1'b0;
    logic [31:0] pa = '0;
    logic [31:0] pd = '0;
    logic        pl = 1'b0;
    for (int i = 0; i < 200 && !done_seen; i++) begin
      @(negedge Clock);
      bus_b.DumpReady = bp ? rdy_pat[i % 6] : 1'b1;
      if (iss_b - acc_b > max_out) max_out = iss_b - acc_b;
      if (prev_stall && (!bus_b.DumpValid || bus_b.DumpAddr != pa ||
                         bus_b.DumpData != pd || bus_b.DumpLast != pl)) stall_bad++;
      if (bus_b.DumpValid && bus_b.DumpReady) begin
        if (nw < 8) begin
          check_eq({tag, "_addr"}, bus_b.DumpAddr, 32'h1000 + 4 * nw);
          check_eq({tag, "_data"}, bus_b.DumpData, 32'hA0 + nw);
          check_eq({tag, "_last"}, 32'(bus_b.DumpLast), 32'(nw == 7));
        end
        nw++;
      end
      prev_stall = bus_b.DumpValid && !bus_b.DumpReady;
      pa = bus_b.DumpAddr;
      pd = bus_b.DumpData;
      pl = bus_b.DumpLast;
      done_seen = Done_b;
    end
    check_eq({tag, "_words"}, nw, 8);
    check_eq({tag, "_done"}, 32'(done_seen), 1);
    check_eq({tag, "_stable"}, stall_bad, 0);
    check_eq({tag, "_outst_le2"}, 32'(max_out <= 2), 1);
  endtask

  initial begin
    int unsigned nw;
    int unsigned done_at;
    int unsigned first_k;
    int unsigned bad;
    int unsigned nacc;

    Rst_a = 1'b1;
    InstValid_a = '0;
    Instr_a = '0;
    bus_a.DumpReady = 1'b1;
    Rst_b = 1'b1;
    InstValid_b = '0;
    Instr_b = '0;
    bus_b.DumpReady = 1'b1;

    // ---- Reset values and opcode trigger (A) ----
    repeat (2) @(negedge Clock);
    check_eq("rst_done",  32'(Done_a), 0);
    check_eq("rst_cause", 32'(EotCause_a), 0);
    check_eq("rst_lane",  32'(EotLane_a), 0);
    check_eq("rst_cnt",   CycleCnt_a, 0);
    check_eq("rst_rden",  32'(bus_a.MemRdEn), 0);
    check_eq("rst_rdadr", bus_a.MemRdAddr, 32'h1000);
    check_eq("rst_valid", 32'(bus_a.DumpValid), 0);
    check_eq("rst_daddr", bus_a.DumpAddr, 0);
    check_eq("rst_ddata", bus_a.DumpData, 0);
    check_eq("rst_dlast", 32'(bus_a.DumpLast), 0);
    Rst_a = 1'b0;
    repeat (10) @(negedge Clock);
    check_eq("pre_trig_cnt", CycleCnt_a, 10);
    InstValid_a = 4'b0001;
    Instr_a = {Nop, Nop, Nop, Ebreak};
    @(negedge Clock);
    InstValid_a = '0;
    check_eq("op_cause", 32'(EotCause_a), 1);
    check_eq("op_lane", 32'(EotLane_a), 0);
    check_eq("op_cnt", CycleCnt_a, 10);
    check_eq("op_first_rden", 32'(bus_a.MemRdEn), 1);
    check_eq("op_first_rdadr", bus_a.MemRdAddr, 32'h1000);
    nw = 0;
    done_at = 0;
    for (int i = 2; i <= 20 && done_at == 0; i++) begin
      @(negedge Clock);
      if (bus_a.DumpValid && bus_a.DumpReady) begin
        if (nw < 4) begin
          check_eq("op_addr", bus_a.DumpAddr, 32'h1000 + 4 * nw);
          check_eq("op_data", bus_a.DumpData, 32'hA0 + nw);
          check_eq("op_last", 32'(bus_a.DumpLast), 32'(nw == 3));
        end
        nw++;
      end
      if (Done_a) done_at = i;
    end
    check_eq("op_words", nw, 4);
    check_eq("op_done_latency", done_at, 7);

    // ---- Sticky DONE (A) ----
    bad = 0;
    InstValid_a = 4'b1111;
    Instr_a = {4{Ebreak}};
    for (int i = 0; i < 10; i++) begin
      bus_a.DumpReady = i[0];
      @(negedge Clock);
      if (!Done_a || bus_a.DumpValid || bus_a.MemRdEn) bad++;
    end
    InstValid_a = '0;
    bus_a.DumpReady = 1'b1;
    check_eq("sticky_cycles", bad, 0);
    check_eq("sticky_done", 32'(Done_a), 1);
    check_eq("sticky_cnt", CycleCnt_a, 10);
    check_eq("sticky_cause", 32'(EotCause_a), 1);
    check_eq("sticky_lane", 32'(EotLane_a), 0);

    // ---- Lane priority (A) ----
    Rst_a = 1'b1;
    repeat (2) @(negedge Clock);
    Rst_a = 1'b0;
    repeat (3) @(negedge Clock);
    InstValid_a = 4'b1110;
    Instr_a = {Ebreak, Nop, Ebreak, Ebreak};
    @(negedge Clock);
    InstValid_a = '0;
    check_eq("prio_cause", 32'(EotCause_a), 1);
    check_eq("prio_lane", 32'(EotLane_a), 1);
    check_eq("prio_cnt", CycleCnt_a, 3);

    // ---- Watchdog (A) ----
    Rst_a = 1'b1;
    repeat (2) @(negedge Clock);
    Rst_a = 1'b0;
    InstValid_a = 4'b1111;
    Instr_a = {4{Nop}};
    first_k = 0;
    for (int k = 1; k <= 60 && first_k == 0; k++) begin
      @(negedge Clock);
      if (EotCause_a != 2'b00) first_k = k;
    end
    InstValid_a = '0;
    check_eq("wd_when", first_k, 50);
    check_eq("wd_cause", 32'(EotCause_a), 2);
    check_eq("wd_lane", 32'(EotLane_a), 0);
    check_eq("wd_cnt", CycleCnt_a, 49);
    check_eq("wd_rden", 32'(bus_a.MemRdEn), 1);

    // ---- Opcode and watchdog in the same cycle (A) ----
    Rst_a = 1'b1;
    repeat (2) @(negedge Clock);
    Rst_a = 1'b0;
    repeat (49) @(negedge Clock);
    check_eq("tie_pre_cnt", CycleCnt_a, 49);
    InstValid_a = 4'b0100;
    Instr_a = {Nop, Ebreak, Nop, Nop};
    @(negedge Clock);
    InstValid_a = '0;
    check_eq("tie_cause", 32'(EotCause_a), 1);
    check_eq("tie_lane", 32'(EotLane_a), 2);
    check_eq("tie_cnt", CycleCnt_a, 49);

    // ---- Backpressure (B) ----
    start_b("bp_trig");
    collect_b(1'b1, "bp");
    bus_b.DumpReady = 1'b1;

    // ---- Reset mid-dump (B) ----
    start_b("rm_trig");
    nacc = 0;
    for (int i = 0; i < 30 && nacc < 3; i++) begin
      @(negedge Clock);
      if (bus_b.DumpValid && bus_b.DumpReady) nacc++;
    end
    check_eq("rm_accepted", nacc, 3);
    @(negedge Clock);
    Rst_b = 1'b1;
    @(negedge Clock);
    Rst_b = 1'b0;
    check_reset_b("rm_rst");
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      if (bus_b.DumpValid || bus_b.MemRdEn) bad++;
    end
    check_eq("rm_no_stale", bad, 0);
    start_b("rm2_trig");
    collect_b(1'b0, "rm2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rvc_asap_eot_ctrl.md
# rvc_asap_eot_ctrl

Synthesizable end-of-test controller for the rvc_asap cores. It watches NUM_LANES retiring-instruction channels for a configurable terminate opcode (default EBREAK) and also runs a cycle watchdog. On either event it freezes the cycle count and walks a data-memory window through a 1-cycle-latency read port. It streams the window out as address/data words over a valid/ready interface, so end-of-test detection and memory snapshot work on FPGA as well as in simulation. It sits beside the core inside the top level, tapping the pipeline's instruction register and a spare D_MEM read port.

## Interface
- NUM_LANES, 1: number of monitored instruction channels; LW = max(1, $clog2(NUM_LANES)).
- EOT_OPCODE, 32'h00100073: instruction word that terminates the test.
- TIMEOUT_CYCLES, 1000000: watchdog limit in cycles; 0 disables the watchdog.
- DUMP_BASE, 'h1000: byte address of the first snapshot word; must be 4-aligned.
- DUMP_WORDS, 1024: number of 32-bit words dumped; must be ≥1.
- Clock  in  1  the single clock, rising edge.
- Rst  in  1  reset, synchronous and active-high.
- InstValid  in  NUM_LANES  lane i carries a valid instruction this cycle.
- Instr  in  32*NUM_LANES  lane i occupies bits [32i+31:32i].
- MemRdEn  out  1  read request to D_MEM.
- MemRdAddr  out  32  byte address of the read request.
- MemRdData  in  32  read data, valid exactly 1 cycle after MemRdEn.
- DumpValid  out  1  snapshot word available.
- DumpReady  in  1  consumer accepts the word.
- DumpAddr  out  32  byte address of the current word.
- DumpData  out  32  data of the current word.
- DumpLast  out  1  the current word is the final one.
- Done  out  1  test finished and dump complete; sticky until Rst.
- EotCause  out  2  00 none, 01 opcode, 10 timeout.
- EotLane  out  LW  lane that matched; 0 on timeout.
- CycleCnt  out  32  cycles spent in RUN; frozen at trigger.

## Operation
- States: RUN → DUMP → DONE. Rst forces RUN from any state.
- **RUN**
  - CycleCnt increments by 1 each cycle and saturates at 32'hFFFFFFFF.
  - A lane matches when InstValid[i]=1 and Instr lane i == EOT_OPCODE. An invalid lane is ignored even if its data matches.
  - Any match: EotCause=01, EotLane=lowest matching lane, go to DUMP.
  - Watchdog fires when TIMEOUT_CYCLES≠0 and CycleCnt == TIMEOUT_CYCLES−1 with no match. Then EotCause=10, EotLane=0, go to DUMP.
  - If a match and the watchdog occur in the same cycle, the opcode cause wins.
  - CycleCnt does not increment in the trigger cycle.
- **DUMP**
  - Issue word addresses DUMP_BASE + 4k for k = 0..DUMP_WORDS−1, in order, one request per MemRdEn cycle.
  - Returned data is written into a 2-entry FIFO whose head drives DumpValid/DumpAddr/DumpData/DumpLast.
  - A read may issue in a cycle only when occupancy + inflight − pop < 2, where pop = DumpValid & DumpReady and inflight is the read issued last cycle.
  - No further reads issue after word DUMP_WORDS−1 has been requested.
  - DumpLast=1 only on the word with k = DUMP_WORDS−1.
- **Dump handshake**
  - Once DumpValid rises, DumpValid/DumpAddr/DumpData/DumpLast stay stable until DumpValid & DumpReady.
  - DumpReady may toggle freely.
- **DONE**
  - Entered in the cycle after the handshake of the DumpLast word.
  - Done=1. Instruction lanes are ignored. CycleCnt, EotCause and EotLane hold until Rst.
- **Reset mid-operation**
  - FIFO is flushed, the in-flight read is discarded (its data is not captured), counters clear, state returns to RUN.
  - The new run starts in the first cycle with Rst=0.

## Timing
- **Reset values:** Done=0, EotCause=00, EotLane=0, CycleCnt=0, MemRdEn=0, MemRdAddr=DUMP_BASE, DumpValid=0, DumpAddr=0, DumpData=0, DumpLast=0.
- **Cycle counting:** the first cycle with Rst=0 shows CycleCnt=0.
- **Trigger in cycle t**
  - State is DUMP at t+1 and the first MemRdEn is at t+1.
  - MemRdData arrives at t+2; the first DumpValid is at t+3.
- **Throughput:** with DumpReady held high, one word per cycle. The last handshake is at t+2+DUMP_WORDS and Done=1 at t+3+DUMP_WORDS.
- **Backpressure:** while DumpReady=0, at most 2 words are buffered plus 0 in flight, so MemRdEn stops.
- **Watchdog:** timeout trigger occurs exactly TIMEOUT_CYCLES cycles after Rst deasserts, provided no match has occurred.

## Test plan
- **Opcode trigger:** NUM_LANES=1, DUMP_WORDS=4, Ready=1; Instr=32'h00100073 valid at CycleCnt=10, memory preloaded with word k = 32'hA0+k → CycleCnt=10, EotCause=01, EotLane=0; words at addresses 'h1000..'h100C with data A0..A3, DumpLast only on 'h100C; Done=1 exactly 7 cycles after the trigger.
- **Lane priority:** NUM_LANES=4; EBREAK on lanes 1 and 3 in the same cycle; lane 0 carries EBREAK with InstValid=0 → EotLane=1, EotCause=01.
- **Watchdog:** TIMEOUT_CYCLES=50, no EBREAK → trigger at CycleCnt=49, EotCause=10, EotLane=0. Separately, EBREAK in the same cycle as the timeout → EotCause=01.
- **Backpressure:** DUMP_WORDS=8, DumpReady pattern 1,0,0,1,0,1,… → all 8 words in order with no loss or duplication; outputs stable while stalled; MemRdEn never leaves more than 2 buffered words.
- **Reset mid-dump:** Rst asserted for 1 cycle after 3 words are accepted → all outputs at reset values the next cycle; the in-flight word never appears; a second EBREAK gives a full dump again starting at 'h1000.
- **Sticky DONE:** additional EBREAKs and DumpReady toggling after Done → Done, CycleCnt, EotCause and EotLane unchanged; DumpValid=0; MemRdEn=0.
